ctrl_regs: RTL
==============

# ctrl_regs

Parametrised control-register bank that sits on the master/slave byte channel bus, next to the other per-function slaves. It holds N_REGS independently writable control registers that drive board-level control outputs: mux address, load switches, DAC modes and supply enables. Over the first-generation bank it adds three things:
- per-register masking and reset values;
- echo readback of every write through the have_msg/rdreq handshake;
- an optional self-clearing pulse mode for strobes.

## Interface
- N_REGS, 9: number of registers and channels.
- DW, 8: register width in bits; equals the master_data width.
- RST_VAL, all zeros: N_REGS*DW packed reset values; register i uses bits [i*DW +: DW].
- WR_MASK, all ones: N_REGS*DW packed writable-bit masks.
- PULSE_MASK, 0: N_REGS bits; bit i set makes register i a pulse register.
- PULSE_CYC, 16: pulse hold length in clk cycles, at least 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- master_data  in  DW  write byte, shared by all channels.
- valid_bus  in  N_REGS  per-channel write strobe.
- rdreq_bus  in  N_REGS  per-channel read/pop request.
- have_msg_bus  out  N_REGS  echo pending for channel i.
- slave_data_bus  out  N_REGS*DW  echo data for channel i.
- len_bus  out  N_REGS*8  pending echo length for channel i, in bytes.
- regs_out  out  N_REGS*DW  current register values.

## Operation
- Write: valid_bus[i] high at a clk edge gives reg[i] <= (master_data & WR_MASK[i]) | (RST_VAL[i] & ~WR_MASK[i]). Non-writable bits hold their reset value.
- Several valid bits may be high in the same cycle. Each addressed channel loads the same master_data.
- Echo: every write sets have_msg[i]=1. While have_msg[i] is high:
  - slave_data[i] = reg[i];
  - len[i] = 1.
  Otherwise len[i] = 0 and slave_data[i] = 0.
- Pop: rdreq_bus[i] while have_msg[i] is high clears have_msg[i] at that edge. rdreq_bus[i] while have_msg[i] is low is ignored.
- Write and rdreq on the same channel in the same cycle: the write wins, and have_msg stays 1 carrying the new value.
- Pulse registers (PULSE_MASK[i]=1):
  - A write loads a per-channel counter cnt[i] <= PULSE_CYC.
  - While cnt[i] != 0, the counter decrements each cycle.
  - At the edge where cnt[i] == 1, reg[i] <= RST_VAL[i] and cnt[i] <= 0.
  - A write while cnt[i] != 0 reloads the value and restarts the count (retrigger).
  - The revert does not set have_msg. An already-pending echo still shows the live value, so after a revert it shows the reset value.
- Non-pulse registers have no counter logic; synthesis removes it.
- Channel state is:
  - IDLE: have_msg=0 and cnt=0.
  - PEND: have_msg=1.
  - HOLD: cnt != 0. HOLD is independent of PEND.

## Timing
- Reset: while rst is high, and immediately after its asynchronous assertion:
  - regs_out = RST_VAL;
  - have_msg_bus = 0;
  - len_bus = 0;
  - slave_data_bus = 0;
  - all counters = 0.
- Reset asserted during a pulse aborts the pulse. There is no revert glitch.
- Write latency: valid at edge t makes regs_out valid from t+1 and have_msg high from t+1.
- Pulse: the written value is visible for exactly PULSE_CYC cycles (t+1 .. t+PULSE_CYC). RST_VAL is visible from t+PULSE_CYC+1.
- Pop latency: rdreq at edge t makes have_msg and len low from t+1.
- slave_data_bus and len_bus are combinational from registered state. No input-to-output combinational path exists.
- Counter width is $clog2(PULSE_CYC+1).

## Structure
- A shared package ctrl_regs_pkg holds:
  - the default RST_VAL, WR_MASK and PULSE_MASK for the BOS board map (channel 0 mux address, 1 loads, 2..6 DAC/level/overvoltage controls, 7..8 supply disables with reset value 1);
  - the message length constant ECHO_LEN=1.
- Sub-module ctrl_reg_chan implements one channel: register, echo flag and optional pulse counter, taking its RST_VAL, WR_MASK and PULSE parameters. ctrl_regs is a generate loop of N_REGS instances plus bus packing.

## Test plan
- Reset with RST_VAL ch7=ch8=8'h01, rest 0 -> regs_out shows 01 on ch7/ch8 and 0 elsewhere; have_msg_bus=0; len_bus=0.
- Write 8'hA5 to ch0 with WR_MASK ch0=8'h0F -> ch0 reads 8'h05 at t+1; have_msg[0]=1; len[0]=1; slave_data[0]=05. rdreq[0] -> have_msg[0]=0 and len[0]=0 next cycle.
- Same-cycle write 8'h01 and rdreq on ch3 while an echo is pending -> have_msg[3] stays 1 and slave_data[3]=01.
- Pulse ch2, PULSE_CYC=4, write 8'h01 at t -> ch2=01 for cycles t+1..t+4 and 00 at t+5. Rewrite at t+2 -> ch2 holds 01 through t+6.
- Simultaneous writes of 8'h01 to ch4/ch5/ch6 -> all three update and all three echo.
- rst pulsed mid-pulse on ch2 -> ch2=RST_VAL immediately; counter stays 0 afterwards with no late revert event.

Source files
------------

// File: rtl/ctrl_regs_pkg.sv
// Shared constants for the control-register bank: BOS board defaults and echo length.
package ctrl_regs_pkg;

  localparam int BOS_N_REGS = 9;
  localparam int BOS_DW     = 8;

  // Channel 8 is the top byte; supply disables (ch7, ch8) come out of reset asserted.
  localparam logic [BOS_N_REGS*BOS_DW-1:0] BOS_RST_VAL =
    {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  localparam logic [BOS_N_REGS*BOS_DW-1:0] BOS_WR_MASK = {BOS_N_REGS*BOS_DW{1'b1}};

  localparam logic [BOS_N_REGS-1:0] BOS_PULSE_MASK = '0;

  localparam logic [7:0] ECHO_LEN = 8'd1;

endpackage

// File: rtl/ctrl_regs_if.sv
// Byte-channel bus between the master and the per-channel control registers.
interface ctrl_regs_if #(
  parameter int N_REGS = 9,
  parameter int DW     = 8
);

  logic [DW-1:0]        master_data;
  logic [N_REGS-1:0]    valid_bus;
  logic [N_REGS-1:0]    rdreq_bus;
  logic [N_REGS-1:0]    have_msg_bus;
  logic [N_REGS*DW-1:0] slave_data_bus;
  logic [N_REGS*8-1:0]  len_bus;

  modport master (
    output master_data, valid_bus, rdreq_bus,
    input  have_msg_bus, slave_data_bus, len_bus
  );

  modport slave (
    input  master_data, valid_bus, rdreq_bus,
    output have_msg_bus, slave_data_bus, len_bus
  );

endinterface

// File: rtl/ctrl_reg_chan.sv
// One control channel: masked register, write-echo flag and optional self-clearing pulse counter.
module ctrl_reg_chan
  import ctrl_regs_pkg::*;
#(
  parameter int            DW        = 8,
  parameter logic [DW-1:0] RST_VAL   = '0,
  parameter logic [DW-1:0] WR_MASK   = '1,
  parameter bit            PULSE     = 1'b0,
  parameter int            PULSE_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          valid,
  input  logic          rdreq,
  output logic          have_msg,
  output logic [DW-1:0] slave_data,
  output logic [7:0]    len,
  output logic [DW-1:0] reg_out
);

  localparam int CW = $clog2(PULSE_CYC + 1);

  logic [DW-1:0] reg_q, reg_d;
  logic          have_msg_q, have_msg_d;
  logic [CW-1:0] cnt_q;
  logic          revert;

  // A write always beats both the pulse revert and a same-cycle pop.
  always_comb begin
    revert     = PULSE && (cnt_q == CW'(1));
    reg_d      = reg_q;
    have_msg_d = have_msg_q;
    if (valid) begin
      reg_d      = (wr_data & WR_MASK) | (RST_VAL & ~WR_MASK);
      have_msg_d = 1'b1;
    end else begin
      if (revert) reg_d = RST_VAL;
      if (rdreq)  have_msg_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q      <= RST_VAL;
      have_msg_q <= 1'b0;
    end else begin
      reg_q      <= reg_d;
      have_msg_q <= have_msg_d;
    end
  end

  generate
    if (PULSE) begin : g_pulse
      logic [CW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (valid)              cnt_d = CW'(PULSE_CYC);
        else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end else begin : g_no_pulse
      assign cnt_q = '0;
    end
  endgenerate

  assign have_msg   = have_msg_q;
  assign slave_data = have_msg_q ? reg_q : '0;
  assign len        = have_msg_q ? ECHO_LEN : 8'd0;
  assign reg_out    = reg_q;

endmodule

// File: rtl/ctrl_regs.sv
// Parametrised bank of N_REGS control registers on the byte-channel bus.
module ctrl_regs
  import ctrl_regs_pkg::*;
#(
  parameter int                   N_REGS     = BOS_N_REGS,
  parameter int                   DW         = BOS_DW,
  parameter logic [N_REGS*DW-1:0] RST_VAL    = '0,
  parameter logic [N_REGS*DW-1:0] WR_MASK    = '1,
  parameter logic [N_REGS-1:0]    PULSE_MASK = '0,
  parameter int                   PULSE_CYC  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_regs_if.slave           bus,
  output logic [N_REGS*DW-1:0] regs_out
);

  genvar i;
  generate
    for (i = 0; i < N_REGS; i++) begin : g_chan
      ctrl_reg_chan #(
        .DW        (DW),
        .RST_VAL   (RST_VAL[i*DW +: DW]),
        .WR_MASK   (WR_MASK[i*DW +: DW]),
        .PULSE     (PULSE_MASK[i]),
        .PULSE_CYC (PULSE_CYC)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (bus.master_data),
        .valid      (bus.valid_bus[i]),
        .rdreq      (bus.rdreq_bus[i]),
        .have_msg   (bus.have_msg_bus[i]),
        .slave_data (bus.slave_data_bus[i*DW +: DW]),
        .len        (bus.len_bus[i*8 +: 8]),
        .reg_out    (regs_out[i*DW +: DW])
      );
    end
  endgenerate

endmodule
